// File: rtl/op_lut_ip_checksum_ttl.sv
// op_lut_ip_checksum_ttl
// Snoops the write bus feeding the output-port-lookup input FIFO and, per packet,
// verifies the IPv4 header checksum, checks ver/IHL and TTL, and produces the
// decremented TTL plus the incrementally updated checksum. Results are queued in a
// small info FIFO whose head is presented combinationally.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr snooped packet word, ctrl (nonzero = module hdr / eop), valid
//   rd_preprocess_info    pop head result (ignored when empty)
//   ip_checksum_vld       result FIFO not empty
//   ip_checksum_is_good   head: header sums to 0xFFFF and header complete
//   ip_hdr_has_options    head: ver/IHL != 0x45
//   ip_ttl_is_good        head: TTL > 1
//   ip_new_ttl            head: TTL-1 (0 when TTL is 0)
//   ip_new_checksum       head: checksum adjusted for the TTL decrement
//   info_fifo_overflow    one-cycle pulse when a result was dropped (FIFO full)
module op_lut_ip_checksum_ttl #(
    parameter int unsigned DATA_WIDTH           = 64,
    parameter int unsigned CTRL_WIDTH           = DATA_WIDTH / 8,
    parameter int unsigned INFO_FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    input  logic                  rd_preprocess_info,
    output logic                  ip_checksum_vld,
    output logic                  ip_checksum_is_good,
    output logic                  ip_hdr_has_options,
    output logic                  ip_ttl_is_good,
    output logic [7:0]            ip_new_ttl,
    output logic [15:0]           ip_new_checksum,
    output logic                  info_fifo_overflow
);

    localparam int unsigned PtrW  = INFO_FIFO_DEPTH_BITS;
    localparam int unsigned Depth = 1 << PtrW;
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(Depth);
    localparam logic [PtrW:0]   CntOne  = 1;
    localparam logic [PtrW-1:0] PtrOne  = 1;

    typedef enum logic [1:0] {StModuleHdrs, StPktHdr, StWaitEop} state_e;

    // Entry layout: {is_good, has_options, ttl_good, new_ttl[7:0], new_checksum[15:0]}
    typedef logic [26:0] entry_t;

    state_e      state_q, state_d;
    logic [2:0]  word_cnt_q;
    logic [19:0] acc_q;
    logic [7:0]  ver_ihl_q;
    logic [7:0]  ttl_q;
    logic [15:0] hc_q;

    logic        eop;
    logic        push;
    entry_t      push_entry;
    logic [19:0] hdr_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [16:0] ck_inc;
    logic [15:0] new_ck;
    logic [7:0]  new_ttl;

    assign eop = |in_ctrl;

    // Final halfword (dst IP lo) is added combinationally so the result can be pushed
    // on the same edge that samples w4.
    assign hdr_sum = acc_q + 20'(in_data[63:48]);
    assign fold1   = {1'b0, hdr_sum[15:0]} + 17'(hdr_sum[19:16]);
    assign fold2   = fold1[15:0] + 16'(fold1[16]);
    assign ck_inc  = {1'b0, hc_q} + 17'h0_0100;
    assign new_ck  = ck_inc[15:0] + 16'(ck_inc[16]);
    assign new_ttl = (ttl_q == 8'd0) ? 8'd0 : ttl_q - 8'd1;

    // FSM next state and result push
    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            StModuleHdrs: begin
                if (in_wr && !eop) state_d = StPktHdr;
            end
            StPktHdr: begin
                if (in_wr) begin
                    if (word_cnt_q == 3'd4) begin
                        push       = 1'b1;
                        push_entry = {fold2 == 16'hFFFF, ver_ihl_q != 8'h45, ttl_q > 8'd1,
                                      new_ttl, new_ck};
                        state_d    = eop ? StModuleHdrs : StWaitEop;
                    end else if (eop) begin
                        // Truncated header: flag as unusable
                        push       = 1'b1;
                        push_entry = {1'b0, 1'b1, 1'b0, 8'd0, 16'd0};
                        state_d    = StModuleHdrs;
                    end
                end
            end
            StWaitEop: begin
                if (in_wr && eop) state_d = StModuleHdrs;
            end
            default: state_d = StModuleHdrs;
        endcase
    end

    // State, word counter, accumulator and header captures
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StModuleHdrs;
            word_cnt_q <= 3'd0;
            acc_q      <= 20'd0;
            ver_ihl_q  <= 8'd0;
            ttl_q      <= 8'd0;
            hc_q       <= 16'd0;
        end else begin
            state_q <= state_d;
            if (in_wr) begin
                if (state_q == StModuleHdrs && !eop) begin
                    word_cnt_q <= 3'd1;
                    acc_q      <= 20'd0;
                end else if (state_q == StPktHdr) begin
                    word_cnt_q <= word_cnt_q + 3'd1;
                    case (word_cnt_q)
                        3'd1: begin
                            acc_q     <= acc_q + 20'(in_data[15:0]);
                            ver_ihl_q <= in_data[15:8];
                        end
                        3'd2: begin
                            acc_q <= acc_q + 20'(in_data[63:48]) + 20'(in_data[47:32])
                                           + 20'(in_data[31:16]) + 20'(in_data[15:0]);
                            ttl_q <= in_data[15:8];
                        end
                        3'd3: begin
                            acc_q <= acc_q + 20'(in_data[63:48]) + 20'(in_data[47:32])
                                           + 20'(in_data[31:16]) + 20'(in_data[15:0]);
                            hc_q  <= in_data[63:48];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Result FIFO
    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q;
    logic            full, pop, do_push, overflow_q;
    entry_t          head;

    assign full    = (cnt_q == CntFull);
    assign pop     = rd_preprocess_info && (cnt_q != '0);
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && full && !pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + CntOne;
                2'b01:   cnt_q <= cnt_q - CntOne;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head fields are forced to zero while empty so stale storage never shows.
    assign ip_checksum_vld    = (cnt_q != '0);
    assign head               = ip_checksum_vld ? mem[rd_ptr_q] : '0;
    assign ip_checksum_is_good = head[26];
    assign ip_hdr_has_options  = head[25];
    assign ip_ttl_is_good      = head[24];
    assign ip_new_ttl          = head[23:16];
    assign ip_new_checksum     = head[15:0];
    assign info_fifo_overflow  = overflow_q;

endmodule

// File: tb/tb_op_lut_ip_checksum_ttl.sv
module tb_op_lut_ip_checksum_ttl;

    typedef struct packed {
        logic        good;
        logic        opts;
        logic        ttl_good;
        logic [7:0]  ttl;
        logic [15:0] ck;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        rd;
    logic        vld, is_good, has_opts, ttl_good, ovf;
    logic [7:0]  new_ttl;
    logic [15:0] new_ck;

    int n_assert = 0;
    int n_fail   = 0;
    entry_t exp_q[$];

    op_lut_ip_checksum_ttl dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .in_ctrl             (in_ctrl),
        .in_wr               (in_wr),
        .rd_preprocess_info  (rd),
        .ip_checksum_vld     (vld),
        .ip_checksum_is_good (is_good),
        .ip_hdr_has_options  (has_opts),
        .ip_ttl_is_good      (ttl_good),
        .ip_new_ttl          (new_ttl),
        .ip_new_checksum     (new_ck),
        .info_fifo_overflow  (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // Header packed as ten halfwords, halfword 0 (ver/IHL,TOS) in the top bits.
    function automatic logic [15:0] hw(input logic [159:0] h, input int i);
        return h[159-16*i -: 16];
    endfunction

    function automatic logic [159:0] set_hw(input logic [159:0] h, input int i,
                                           input logic [15:0] v);
        logic [159:0] r;
        r = h;
        r[159-16*i -: 16] = v;
        return r;
    endfunction

    function automatic logic [15:0] ones_sum(input logic [159:0] h);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 10; i++) s = s + 32'(hw(h, i));
        s = 32'(s[15:0]) + 32'(s[31:16]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        return s[15:0];
    endfunction

    function automatic logic [159:0] fix_hc(input logic [159:0] h);
        logic [159:0] r;
        r = set_hw(h, 5, 16'h0000);
        return set_hw(r, 5, ~ones_sum(r));
    endfunction

    function automatic entry_t exp_full(input logic [159:0] h);
        entry_t      e;
        logic [15:0] w;
        logic [7:0]  t;
        logic [16:0] c;
        w = hw(h, 4);
        t = w[15:8];
        w = hw(h, 0);
        e.good     = (ones_sum(h) == 16'hFFFF);
        e.opts     = (w[15:8] != 8'h45);
        e.ttl_good = (t > 8'd1);
        e.ttl      = (t == 8'd0) ? 8'd0 : t - 8'd1;
        c          = {1'b0, hw(h, 5)} + 17'h0_0100;
        e.ck       = c[15:0] + 16'(c[16]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        in_wr   = 1'b1;
        in_data = d;
        in_ctrl = c;
        step();
    endtask

    task automatic idle();
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        step();
    endtask

    function automatic logic [31:0] head_obs();
        return 32'({is_good, has_opts, ttl_good, new_ttl, new_ck});
    endfunction

    // Scoreboard push: returns whether the model expects the entry to be dropped.
    task automatic model_push(input entry_t e, output bit dropped);
        if (exp_q.size() < 4) begin
            exp_q.push_back(e);
            dropped = 1'b0;
        end else begin
            dropped = 1'b1;
        end
    endtask

    task automatic send_pkt(input string tag, input logic [159:0] h, input int short_at,
                            input bit eop_w4, input bit pop_w4);
        logic [63:0] w [5];
        entry_t      e;
        bit          dropped;
        w[0] = 64'h0011_2233_4455_6677;
        w[1] = {48'hAABB_CCDD_EEFF, hw(h, 0)};
        w[2] = {hw(h, 1), hw(h, 2), hw(h, 3), hw(h, 4)};
        w[3] = {hw(h, 5), hw(h, 6), hw(h, 7), hw(h, 8)};
        w[4] = {hw(h, 9), 48'h1234_5678_9ABC};
        drive(64'hFFFF_0000_0000_0040, 8'hFF);
        check({tag, "_ovf_low"}, 32'(ovf), 32'd0);
        drive(w[0], 8'h00);
        for (int k = 1; k <= 3; k++) begin
            if (short_at == k) begin
                drive(w[k], 8'h80);
                e = '0;
                e.opts = 1'b1;
                model_push(e, dropped);
                check({tag, "_short_vld"}, 32'(vld), 32'(exp_q.size() != 0));
                check({tag, "_short_ovf"}, 32'(ovf), 32'(dropped));
                return;
            end
            drive(w[k], 8'h00);
        end
        check({tag, "_vld_before_w4"}, 32'(vld), 32'(exp_q.size() != 0));
        if (pop_w4) begin
            rd = 1'b1;
            if (exp_q.size() != 0) check({tag, "_head_at_pop"}, head_obs(), 32'(exp_q[0]));
        end
        drive(w[4], eop_w4 ? 8'h01 : 8'h00);
        rd = 1'b0;
        if (pop_w4 && exp_q.size() != 0) void'(exp_q.pop_front());
        model_push(exp_full(h), dropped);
        check({tag, "_vld_after_w4"}, 32'(vld), 32'(exp_q.size() != 0));
        check({tag, "_ovf_after_w4"}, 32'(ovf), 32'(dropped));
        if (!eop_w4) begin
            drive(64'hDEAD_BEEF_0000_0000, 8'h01);
            check({tag, "_ovf_clears"}, 32'(ovf), 32'd0);
        end
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_vld"}, 32'(vld), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, "_head"}, head_obs(), 32'(exp_q[0]));
        rd = 1'b1;
        step();
        rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check({tag, "_vld_after"}, 32'(vld), 32'(exp_q.size() != 0));
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    localparam logic [159:0] Base =
        160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

    initial begin
        logic [159:0] h;
        reset   = 1'b1;
        in_wr   = 1'b0;
        in_data = 64'd0;
        in_ctrl = 8'd0;
        rd      = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_vld", 32'(vld), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_head", head_obs(), 32'd0);

        // Reference header, known-good checksum
        send_pkt("p1", Base, 0, 1'b0, 1'b0);
        idle();
        check("p1_good", 32'(is_good), 32'd1);
        check("p1_new_ttl", 32'(new_ttl), 32'h3F);
        check("p1_new_ck", 32'(new_ck), 32'hB961);
        pop_check("p1_pop");

        // Corrupted checksum
        send_pkt("bad_hc", set_hw(Base, 5, 16'hB862), 0, 1'b0, 1'b0);
        idle();
        check("bad_hc_good", 32'(is_good), 32'd0);
        pop_check("bad_hc_pop");

        // TTL 1 and TTL 0 with valid sums
        send_pkt("ttl1", fix_hc(set_hw(Base, 4, 16'h0111)), 0, 1'b0, 1'b0);
        send_pkt("ttl0", fix_hc(set_hw(Base, 4, 16'h0011)), 0, 1'b0, 1'b0);
        idle();
        pop_check("ttl1_pop");
        pop_check("ttl0_pop");

        // Options present, then truncated packet ending on w2
        send_pkt("opt", fix_hc(set_hw(Base, 0, 16'h4600)), 0, 1'b0, 1'b0);
        idle();
        pop_check("opt_pop");
        send_pkt("short", Base, 2, 1'b0, 1'b0);
        idle();
        pop_check("short_pop");

        // Push and pop together while empty: entry kept
        send_pkt("empty_pp", Base, 0, 1'b0, 1'b1);
        idle();
        pop_check("empty_pp_pop");

        // Five back-to-back packets, no idle cycles, no pops: fifth dropped
        for (int i = 0; i < 5; i++) begin
            h = fix_hc(set_hw(Base, 7, 16'(i + 1)));
            send_pkt($sformatf("b2b%0d", i), h, 0, 1'b1, 1'b0);
        end
        idle();
        check("b2b_ovf_gone", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("b2b_pop%0d", i));

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            h = fix_hc(set_hw(Base, 8, 16'(i + 16'h10)));
            send_pkt($sformatf("fill%0d", i), h, 0, 1'b1, 1'b0);
        end
        send_pkt("full_pp", fix_hc(set_hw(Base, 8, 16'h0077)), 0, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) pop_check($sformatf("full_pop%0d", i));

        // Reset during w2 of a packet while an entry is queued
        send_pkt("pre_rst", Base, 0, 1'b0, 1'b0);
        drive(64'hFFFF_0000_0000_0040, 8'hFF);
        drive(64'h0011_2233_4455_6677, 8'h00);
        drive({48'hAABB_CCDD_EEFF, 16'h4500}, 8'h00);
        in_data = 64'h0073_0000_4000_4011;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        in_wr = 1'b0;
        exp_q.delete();
        check("rst_mid_vld", 32'(vld), 32'd0);
        check("rst_mid_head", head_obs(), 32'd0);
        step();
        send_pkt("post_rst", Base, 0, 1'b0, 1'b0);
        idle();
        pop_check("post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
